phase_accumulator: RTL and testbench

- Numerically controlled phase generator sitting directly upstream of the quarter-wave sine LUT.
- Produces the LUT's `i_phase` word once per enabled clock from a programmable frequency tuning word (FTW) and a static phase offset.
- FTW updates are double-buffered and applied phase-continuously at the accumulator wrap, so the sine/cosine outputs never glitch on a frequency change.
- Emits a wrap pulse marking each waveform period, for downstream demodulation/timing.

---
 rtl/phase_accumulator.sv | 212 +++++++++++++++++++++
 tb/tb_phase_accumulator.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/phase_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : phase_accumulator
//  Purpose  : Numerically controlled phase generator feeding the quarter-wave
//             sine LUT. Accumulates a frequency tuning word (FTW) each enabled
//             clock, truncates to O_WIDTH bits, adds a static phase offset and
//             registers the result as the LUT phase word. FTW changes are
//             double-buffered and applied at the accumulator wrap so the
//             generated waveform stays phase-continuous.
//  Ports    : i_clk        - system clock, rising edge
//             i_rst        - synchronous active-high reset
//             i_en         - accumulation / output clock enable
//             i_ftw        - offered frequency tuning word
//             i_ftw_valid  - FTW offer valid
//             o_ftw_ready  - FTW can be accepted this cycle (registered)
//             i_phase_off  - phase offset added after truncation
//             i_sync       - pulse that zeroes the accumulator
//             o_phase      - registered phase word for the sine LUT
//             o_valid      - o_phase is live
//             o_wrap       - accumulator overflowed on the previous update
//  Options  : `define PHASE_DITHER_EN adds LFSR dither before truncation
//             (one extra pipeline stage on o_phase and o_wrap).
//  Revision : 1.0  initial release
// ============================================================================
module phase_accumulator #(
    parameter int ACC_WIDTH = 24,
    parameter int O_WIDTH   = 11
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic [ACC_WIDTH-1:0] i_ftw,
    input  logic                 i_ftw_valid,
    output logic                 o_ftw_ready,
    input  logic [O_WIDTH-1:0]   i_phase_off,
    input  logic                 i_sync,
    output logic [O_WIDTH-1:0]   o_phase,
    output logic                 o_valid,
    output logic                 o_wrap
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_ARMED = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic [ACC_WIDTH-1:0]   w_acc_nxt;
    logic [ACC_WIDTH-1:0]   r_ftw_active;
    logic [ACC_WIDTH-1:0]   w_ftw_active_nxt;
    logic [ACC_WIDTH-1:0]   r_ftw_pending;
    logic [ACC_WIDTH-1:0]   w_ftw_pending_nxt;
    logic                   r_ftw_ready;
    logic [ACC_WIDTH:0]     w_sum;
    logic                   w_carry;
    logic                   w_xfer;
    logic                   w_wrap;

    logic [O_WIDTH-1:0]     r_phase;
    logic                   r_valid;
    logic                   r_wrap;

    assign w_xfer  = i_ftw_valid && r_ftw_ready;
    assign w_sum   = {1'b0, r_acc} + {1'b0, r_ftw_active};
    assign w_carry = w_sum[ACC_WIDTH];

    // ------------------------------------------------------------------
    // Next-state / accumulator control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        w_acc_nxt         = r_acc;
        w_ftw_active_nxt  = r_ftw_active;
        w_ftw_pending_nxt = r_ftw_pending;
        w_wrap            = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_acc_nxt = '0;
                if (w_xfer) begin
                    w_ftw_active_nxt = i_ftw;
                    w_state_nxt      = S_RUN;
                end
            end

            S_RUN: begin
                if (i_sync) begin
                    w_acc_nxt = '0;
                end else if (i_en) begin
                    w_acc_nxt = w_sum[ACC_WIDTH-1:0];
                    w_wrap    = w_carry;
                end
                // A transfer coinciding with a wrap or sync is only parked;
                // it is applied at the following wrap.
                if (w_xfer) begin
                    w_ftw_pending_nxt = i_ftw;
                    w_state_nxt       = S_ARMED;
                end
            end

            S_ARMED: begin
                if (i_sync) begin
                    w_acc_nxt        = '0;
                    w_ftw_active_nxt = r_ftw_pending;
                    w_state_nxt      = S_RUN;
                end else begin
                    if (i_en) begin
                        w_acc_nxt = w_sum[ACC_WIDTH-1:0];
                        w_wrap    = w_carry;
                    end
                    // A zero active FTW can never wrap, so swap it in at once
                    // regardless of the enable.
                    if ((r_ftw_active == '0) || (i_en && w_carry)) begin
                        w_ftw_active_nxt = r_ftw_pending;
                        w_state_nxt      = S_RUN;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_acc         <= '0;
            r_ftw_active  <= '0;
            r_ftw_pending <= '0;
            r_ftw_ready   <= 1'b1;
        end else begin
            r_state       <= w_state_nxt;
            r_acc         <= w_acc_nxt;
            r_ftw_active  <= w_ftw_active_nxt;
            r_ftw_pending <= w_ftw_pending_nxt;
            r_ftw_ready   <= (w_state_nxt != S_ARMED);
        end
    end

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
`ifdef PHASE_DITHER_EN
    localparam int DITHER_BITS = ACC_WIDTH - O_WIDTH;

    logic [15:0]          r_lfsr;
    logic                 w_lfsr_fb;
    logic [ACC_WIDTH-1:0] w_dither;
    logic [ACC_WIDTH-1:0] r_dith_acc;
    logic                 r_wrap_d;

    // Fibonacci form of x^16+x^14+x^13+x^11+1
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_comb begin
        w_dither = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < DITHER_BITS) begin
                w_dither[i] = r_lfsr[i];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lfsr     <= 16'hACE1;
            r_dith_acc <= '0;
            r_wrap_d   <= 1'b0;
            r_phase    <= '0;
            r_valid    <= 1'b0;
            r_wrap     <= 1'b0;
        end else begin
            r_valid <= i_en && (r_state != S_IDLE);
            if (i_en) begin
                r_lfsr     <= {r_lfsr[14:0], w_lfsr_fb};
                r_dith_acc <= r_acc + w_dither;
                r_phase    <= r_dith_acc[ACC_WIDTH-1 -: O_WIDTH] + i_phase_off;
                r_wrap_d   <= w_wrap;
                r_wrap     <= r_wrap_d;
            end else begin
                r_wrap     <= 1'b0;
            end
        end
    end
`else
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_phase <= '0;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_valid <= i_en && (r_state != S_IDLE);
            r_wrap  <= w_wrap;      // already zero when disabled or syncing
            if (i_en) begin
                r_phase <= r_acc[ACC_WIDTH-1 -: O_WIDTH] + i_phase_off;
            end
        end
    end
`endif

    assign o_phase     = r_phase;
    assign o_valid     = r_valid;
    assign o_wrap      = r_wrap;
    assign o_ftw_ready = r_ftw_ready;

endmodule
`default_nettype wire

// File: tb/tb_phase_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_phase_accumulator
//  Purpose  : Self-checking bench for phase_accumulator (ACC_WIDTH=24,
//             O_WIDTH=11). A per-cycle vector table covers reset, ramp,
//             enable gating, sync, offset, FTW handshake and zero-FTW apply;
//             hand-written loops cover full-period wrap timing and the
//             phase-continuous FTW change at the wrap.
//  Revision : 1.0  initial release
// ============================================================================
module tb_phase_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [23:0] ftw = '0;
    logic        ftw_valid = 1'b0;
    logic        ftw_ready;
    logic [10:0] phase_off = '0;
    logic        sync = 1'b0;
    logic [10:0] phase;
    logic        valid;
    logic        wrap;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    phase_accumulator #(
        .ACC_WIDTH (24),
        .O_WIDTH   (11)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .i_ftw       (ftw),
        .i_ftw_valid (ftw_valid),
        .o_ftw_ready (ftw_ready),
        .i_phase_off (phase_off),
        .i_sync      (sync),
        .o_phase     (phase),
        .o_valid     (valid),
        .o_wrap      (wrap)
    );

    typedef struct {
        logic        rst;
        logic        en;
        logic        fv;
        logic [23:0] ftw;
        logic        sync;
        logic [10:0] off;
        logic [10:0] ph;
        logic        v;
        logic        w;
        logic        rdy;
    } vec_t;

    vec_t vecs [35];

    function automatic vec_t mkv(input int r, input int e, input int f, input int t,
                                 input int s, input int o, input int p, input int v,
                                 input int w, input int rdy);
        vec_t x;
        x.rst  = 1'(r);
        x.en   = 1'(e);
        x.fv   = 1'(f);
        x.ftw  = 24'(t);
        x.sync = 1'(s);
        x.off  = 11'(o);
        x.ph   = 11'(p);
        x.v    = 1'(v);
        x.w    = 1'(w);
        x.rdy  = 1'(rdy);
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic f, input logic [23:0] t,
                         input logic s, input logic [10:0] o);
        rst       = r;
        en        = e;
        ftw_valid = f;
        ftw       = t;
        sync      = s;
        phase_off = o;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //                rst en fv ftw    sy off  | ph   v  w  rdy
        vecs[0]  = mkv(1, 0, 0, 0,     0, 0,     0,   0, 0, 1);
        vecs[1]  = mkv(0, 1, 1, 16384, 0, 0,     0,   0, 0, 1);
        vecs[2]  = mkv(0, 1, 0, 0,     0, 0,     0,   1, 0, 1);
        vecs[3]  = mkv(0, 1, 0, 0,     0, 0,     2,   1, 0, 1);
        vecs[4]  = mkv(0, 1, 0, 0,     0, 0,     4,   1, 0, 1);
        vecs[5]  = mkv(0, 0, 0, 0,     0, 0,     4,   0, 0, 1);
        vecs[6]  = mkv(0, 0, 0, 0,     0, 0,     4,   0, 0, 1);
        vecs[7]  = mkv(0, 1, 0, 0,     0, 0,     6,   1, 0, 1);
        vecs[8]  = mkv(0, 1, 0, 0,     1, 0,     8,   1, 0, 1);
        vecs[9]  = mkv(0, 1, 0, 0,     0, 0,     0,   1, 0, 1);
        vecs[10] = mkv(0, 1, 0, 0,     0, 1500,  1502, 1, 0, 1);
        vecs[11] = mkv(0, 1, 0, 0,     1, 1500,  1504, 1, 0, 1);
        vecs[12] = mkv(0, 1, 0, 0,     0, 1500,  1500, 1, 0, 1);
        vecs[13] = mkv(0, 1, 0, 0,     0, 0,     2,   1, 0, 1);
        vecs[14] = mkv(0, 1, 1, 32768, 0, 0,     4,   1, 0, 0);
        vecs[15] = mkv(0, 1, 1, 32768, 0, 0,     6,   1, 0, 0);
        vecs[16] = mkv(0, 1, 0, 0,     1, 0,     8,   1, 0, 1);
        vecs[17] = mkv(0, 1, 0, 0,     0, 0,     0,   1, 0, 1);
        vecs[18] = mkv(0, 1, 0, 0,     0, 0,     4,   1, 0, 1);
        vecs[19] = mkv(0, 1, 1, 0,     0, 0,     8,   1, 0, 0);
        vecs[20] = mkv(0, 1, 0, 0,     1, 0,     12,  1, 0, 1);
        vecs[21] = mkv(0, 1, 0, 0,     0, 0,     0,   1, 0, 1);
        vecs[22] = mkv(0, 1, 0, 0,     0, 0,     0,   1, 0, 1);
        vecs[23] = mkv(0, 1, 1, 8192,  0, 0,     0,   1, 0, 0);
        vecs[24] = mkv(0, 0, 0, 0,     0, 0,     0,   0, 0, 1);
        vecs[25] = mkv(0, 1, 0, 0,     0, 0,     0,   1, 0, 1);
        vecs[26] = mkv(0, 1, 0, 0,     0, 0,     1,   1, 0, 1);
        vecs[27] = mkv(0, 1, 0, 0,     0, 0,     2,   1, 0, 1);
        vecs[28] = mkv(0, 1, 1, 65536, 0, 0,     3,   1, 0, 0);
        vecs[29] = mkv(1, 1, 0, 0,     0, 0,     0,   0, 0, 1);
        vecs[30] = mkv(0, 1, 1, 8192,  0, 0,     0,   0, 0, 1);
        vecs[31] = mkv(0, 1, 0, 0,     0, 0,     0,   1, 0, 1);
        vecs[32] = mkv(0, 1, 0, 0,     0, 0,     1,   1, 0, 1);
        vecs[33] = mkv(0, 1, 0, 0,     0, 0,     2,   1, 0, 1);
        vecs[34] = mkv(0, 1, 0, 0,     0, 0,     3,   1, 0, 1);

        // ---------------- table-driven cycle vectors ----------------
        for (int i = 0; i < 35; i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].fv, vecs[i].ftw, vecs[i].sync, vecs[i].off);
            tick();
            chk($sformatf("vec%0d.phase", i), 32'(phase),     32'(vecs[i].ph));
            chk($sformatf("vec%0d.valid", i), 32'(valid),     32'(vecs[i].v));
            chk($sformatf("vec%0d.wrap",  i), 32'(wrap),      32'(vecs[i].w));
            chk($sformatf("vec%0d.ready", i), 32'(ftw_ready), 32'(vecs[i].rdy));
        end

        // ---------------- two full periods, FTW=16384 ----------------
        drive(1, 0, 0, 24'd0, 0, 11'd0);
        tick();
        drive(0, 1, 1, 24'd16384, 0, 11'd0);
        tick();
        drive(0, 1, 0, 24'd0, 0, 11'd0);
        for (int n = 1; n <= 2050; n++) begin
            tick();
            chk("ramp.phase", 32'(phase), 32'((2 * (n - 1)) % 2048));
            chk("ramp.wrap",  32'(wrap),  32'((n % 1024) == 0));
        end

        // ------- offset wrap, then FTW change applied at the wrap -------
        drive(1, 0, 0, 24'd0, 0, 11'd0);
        tick();
        drive(0, 1, 1, 24'd16384, 0, 11'd0);
        tick();
        drive(0, 1, 0, 24'd0, 0, 11'd0);
        for (int n = 1; n <= 300; n++) begin
            tick();
        end
        drive(0, 1, 0, 24'd0, 0, 11'd1500);
        tick();
        chk("offset.phase", 32'(phase), 32'd52);
        drive(0, 1, 1, 24'd32768, 0, 11'd0);
        tick();
        chk("offer.phase", 32'(phase),     32'd602);
        chk("offer.ready", 32'(ftw_ready), 32'd0);
        drive(0, 1, 0, 24'd0, 0, 11'd0);
        for (int n = 303; n <= 1023; n++) begin
            tick();
            chk("armed.phase", 32'(phase),     32'(2 * (n - 1)));
            chk("armed.ready", 32'(ftw_ready), 32'd0);
            chk("armed.wrap",  32'(wrap),      32'd0);
        end
        tick();
        chk("apply.phase", 32'(phase),     32'd2046);
        chk("apply.wrap",  32'(wrap),      32'd1);
        chk("apply.ready", 32'(ftw_ready), 32'd1);
        tick();
        chk("newftw.phase0", 32'(phase), 32'd0);
        tick();
        chk("newftw.phase1", 32'(phase), 32'd4);
        tick();
        chk("newftw.phase2", 32'(phase), 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
